uart_rx_frame: RTL and testbench
================================

Name: uart_rx_frame

Overview:
- Parametrised UART receiver for the debug-transport UART interface; successor to the fixed 8N1 receiver.
- Adds configurable data width, parity, one or two stop bits, and false-start rejection.
- Adds framing/parity error flags, break detection, and a valid/ready output handshake with overrun reporting.
- Sits between the RX pad and the DMI/debug protocol FSM.

Parameters:
- OVERSAMPLING, 16, oversampling factor; CLKS_PER_BIT = OVERSAMPLING*BDDIVIDER.
- BDDIVIDER, 27, clock divider per oversample tick.
- DATA_BITS, 8, data bits per frame; legal range 5..9.
- PARITY, 0, parity mode: 0 = none, 1 = odd, 2 = even.
- STOP_BITS, 1, number of stop bits; legal values 1 or 2.

Ports:
- CLK_I  in  1  system clock.
- RST_I  in  1  synchronous, active-high reset.
- RX_I  in  1  asynchronous serial line; idle high.
- DATA_O  out  DATA_BITS  received word, LSB is the first bit received.
- VALID_O  out  1  DATA_O and error flags are valid.
- READY_I  in  1  consumer accepts the word.
- PARITY_ERR_O  out  1  parity mismatch on the held word; qualified by VALID_O.
- FRAME_ERR_O  out  1  a stop bit was sampled low on the held word; qualified by VALID_O.
- BREAK_O  out  1  one-cycle pulse when a break is detected.
- OVERRUN_O  out  1  one-cycle pulse when a frame is dropped.
- BUSY_O  out  1  high whenever the FSM is not in IDLE.

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high, on CLK_I / RST_I.
- Reset values: all outputs 0; FSM in IDLE; synchroniser flops reset to 1.
- Reset mid-frame aborts the frame with no output.
- Input path: RX_I passes through a 2-flop synchroniser (rx_s); a previous-value register gives edge detection.
- Timing reference: T = first cycle in which rx_s is 0 while the previous value is 1, with the FSM in IDLE.
- Sample instants: bit k (k = 0 is the start bit) is sampled at cycle T + CLKS_PER_BIT/2 + k*CLKS_PER_BIT, from a single down-counter.
  - Counter is reloaded with CLKS_PER_BIT/2-1 on start detection.
  - Counter is reloaded with CLKS_PER_BIT-1 after every sample.
- FSM states and transitions:
  - IDLE -> START on a falling edge.
  - START: at the sample, rx_s == 1 -> IDLE (glitch rejected, no flags); otherwise -> DATA.
  - DATA: shift in DATA_BITS samples, LSB first. Then -> PAR if PARITY != 0, else -> STOP.
  - PAR: one sample. Error when the XOR of data bits and the parity bit is 0 for odd parity, or 1 for even parity.
  - STOP: STOP_BITS samples. Frame error if any stop sample is 0.
  - On the last stop sample: commit, then -> IDLE. The FSM re-arms mid-stop-bit, so back-to-back frames are supported.
  - BRK_WAIT: stay until rx_s == 1, then -> IDLE. No start detection while in BRK_WAIT.
- Break detection: at commit, if all data bits, the parity bit (when present) and the first stop sample are 0:
  - BREAK_O pulses for one cycle in the cycle after commit; go to BRK_WAIT.
  - No word is delivered and OVERRUN_O is not asserted.
- Delivery at commit (non-break):
  - If VALID_O == 0, or READY_I == 1 in the commit cycle: load DATA_O and both error flags, and set VALID_O on the next cycle.
  - If VALID_O == 1 and READY_I == 0: the new frame is dropped and OVERRUN_O pulses next cycle. The held word and flags are unchanged.
- Handshake:
  - VALID_O is cleared the cycle after VALID_O && READY_I, unless a commit loads a new word in the same cycle, in which case VALID_O stays 1.
  - DATA_O and the flags are stable while VALID_O is 1 and READY_I is 0.
- RX_I held low through reset release: the start is detected and the frame resolves as a break; the block then waits in BRK_WAIT for the line to go high.
- Counters are integer width, at least clog2(CLKS_PER_BIT)+1 bits. No wrap occurs because the counter is reloaded before underflow.

Test Plan:
- Config OVERSAMPLING=4, BDDIVIDER=2 (8 clocks/bit), 8N1, READY_I tied 1. Send 0xA5 -> VALID_O for one cycle, DATA_O=0xA5, both error flags 0, VALID_O rising at T+4+9*8+1.
- DATA_BITS=7, PARITY=2 (even), STOP_BITS=2. Send 0x55 with parity bit 0 -> DATA_O=0x55, PARITY_ERR_O=0. Resend with parity bit 1 -> PARITY_ERR_O=1.
- 8N1, send 0x3C with stop bit 0 (line high afterwards) -> DATA_O=0x3C, FRAME_ERR_O=1, BREAK_O stays 0.
- Line low for 20 bit times -> BREAK_O one pulse, VALID_O stays 0, BUSY_O high until the line returns high. Then send 0x81 -> received correctly.
- READY_I=0. Send 0x11 then 0x22 back-to-back -> VALID_O high with DATA_O=0x11, OVERRUN_O pulses once. Raise READY_I -> VALID_O falls, 0x22 never appears.
- Extra cases:
  - Low glitch of 2 clocks -> START rejected, BUSY_O returns to 0, no outputs.
  - RST_I asserted mid-DATA -> all outputs 0 next cycle; a following clean 0x5A frame is received correctly.

Source files
------------

// File: rtl/uart_rx_frame.sv
// Parametrised UART receiver: configurable width, parity and stop bits, with
// error flags, break detection and a valid/ready output with overrun pulses.
module uart_rx_frame #(
    parameter int OVERSAMPLING = 16,
    parameter int BDDIVIDER    = 27,
    parameter int DATA_BITS    = 8,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic                 CLK_I,
    input  logic                 RST_I,
    input  logic                 RX_I,
    output logic [DATA_BITS-1:0] DATA_O,
    output logic                 VALID_O,
    input  logic                 READY_I,
    output logic                 PARITY_ERR_O,
    output logic                 FRAME_ERR_O,
    output logic                 BREAK_O,
    output logic                 OVERRUN_O,
    output logic                 BUSY_O
);

    localparam int CLKS_PER_BIT = OVERSAMPLING * BDDIVIDER;
    localparam int CNT_W        = $clog2(CLKS_PER_BIT) + 1;

    localparam logic [CNT_W-1:0] HALF_RELOAD = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] BIT_RELOAD  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [3:0]       LAST_DATA   = 4'(DATA_BITS - 1);
    localparam logic             LAST_STOP   = 1'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PAR,
        S_STOP,
        S_BRK_WAIT
    } state_t;

    state_t                 state;
    logic                   rx_meta;
    logic                   rx_s;
    logic                   rx_prev;
    logic [CNT_W-1:0]       cnt;
    logic [3:0]             bit_idx;
    logic                   stop_idx;
    logic [DATA_BITS-1:0]   shreg;
    logic                   par_bit_q;
    logic                   par_err_q;
    logic                   frame_err_q;
    logic                   first_stop_q;

    logic                   tick;
    logic                   fall;
    logic                   frame_err_nxt;
    logic                   first_stop_nxt;
    logic                   is_break;
    logic                   par_xor;

    assign tick   = (cnt == '0);
    assign fall   = ~rx_s & rx_prev;
    assign BUSY_O = (state != S_IDLE);

    // Commit-time view of the frame, including the stop sample being taken now.
    always_comb begin
        frame_err_nxt  = frame_err_q | ~rx_s;
        first_stop_nxt = (stop_idx == 1'b0) ? rx_s : first_stop_q;
        is_break       = (shreg == '0) && ((PARITY == 0) || !par_bit_q) && !first_stop_nxt;
        par_xor        = (^shreg) ^ rx_s;
    end

    always_ff @(posedge CLK_I) begin
        if (RST_I) begin
            rx_meta      <= 1'b1;
            rx_s         <= 1'b1;
            rx_prev      <= 1'b1;
            state        <= S_IDLE;
            cnt          <= '0;
            bit_idx      <= '0;
            stop_idx     <= 1'b0;
            shreg        <= '0;
            par_bit_q    <= 1'b0;
            par_err_q    <= 1'b0;
            frame_err_q  <= 1'b0;
            first_stop_q <= 1'b1;
            DATA_O       <= '0;
            VALID_O      <= 1'b0;
            PARITY_ERR_O <= 1'b0;
            FRAME_ERR_O  <= 1'b0;
            BREAK_O      <= 1'b0;
            OVERRUN_O    <= 1'b0;
        end else begin
            rx_meta   <= RX_I;
            rx_s      <= rx_meta;
            rx_prev   <= rx_s;
            BREAK_O   <= 1'b0;
            OVERRUN_O <= 1'b0;

            // NOTE: later non-blocking writes win, so a commit below overrides this clear.
            if (VALID_O && READY_I)
                VALID_O <= 1'b0;

            if (state != S_IDLE && state != S_BRK_WAIT)
                cnt <= tick ? BIT_RELOAD : cnt - CNT_W'(1);

            case (state)
                S_IDLE: begin
                    if (fall) begin
                        state <= S_START;
                        cnt   <= HALF_RELOAD;
                    end
                end

                S_START: begin
                    if (tick) begin
                        if (rx_s) begin
                            state <= S_IDLE;
                        end else begin
                            state       <= S_DATA;
                            bit_idx     <= '0;
                            stop_idx    <= 1'b0;
                            par_bit_q   <= 1'b0;
                            par_err_q   <= 1'b0;
                            frame_err_q <= 1'b0;
                        end
                    end
                end

                S_DATA: begin
                    if (tick) begin
                        shreg   <= {rx_s, shreg[DATA_BITS-1:1]};
                        bit_idx <= bit_idx + 4'd1;
                        if (bit_idx == LAST_DATA)
                            state <= (PARITY != 0) ? S_PAR : S_STOP;
                    end
                end

                S_PAR: begin
                    if (tick) begin
                        par_bit_q <= rx_s;
                        par_err_q <= (PARITY == 1) ? ~par_xor : par_xor;
                        state     <= S_STOP;
                    end
                end

                S_STOP: begin
                    if (tick) begin
                        frame_err_q  <= frame_err_nxt;
                        first_stop_q <= first_stop_nxt;
                        stop_idx     <= ~stop_idx;
                        if (stop_idx == LAST_STOP) begin
                            if (is_break) begin
                                BREAK_O <= 1'b1;
                                state   <= S_BRK_WAIT;
                            end else begin
                                // Re-arm mid-stop-bit so a back-to-back start edge is caught.
                                state <= S_IDLE;
                                if (!VALID_O || READY_I) begin
                                    DATA_O       <= shreg;
                                    PARITY_ERR_O <= par_err_q;
                                    FRAME_ERR_O  <= frame_err_nxt;
                                    VALID_O      <= 1'b1;
                                end else begin
                                    OVERRUN_O <= 1'b1;
                                end
                            end
                        end
                    end
                end

                S_BRK_WAIT: begin
                    if (rx_s)
                        state <= S_IDLE;
                end

                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx_frame.sv
// Scoreboard bench for uart_rx_frame: an 8N1 instance and a 7E2 instance,
// both at 8 clocks per bit.
module tb_uart_rx_frame;

    localparam int CPB = 8;

    typedef struct packed {
        logic [8:0] data;
        logic       perr;
        logic       ferr;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx8 = 1'b1;
    logic       rx7 = 1'b1;
    logic       ready8 = 1'b1;
    logic       ready7 = 1'b1;

    logic [7:0] data8;
    logic       valid8, perr8, ferr8, brk8, ovr8, busy8;
    logic [6:0] data7;
    logic       valid7, perr7, ferr7, brk7, ovr7, busy7;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int lat_start = 0;
    bit lat_armed = 1'b0;
    int valid_cycles8 = 0;
    int brk_cnt8 = 0;
    int ovr_cnt8 = 0;
    int brk_cnt7 = 0;
    int ovr_cnt7 = 0;

    exp_t q8[$];
    exp_t q7[$];

    uart_rx_frame #(
        .OVERSAMPLING(4), .BDDIVIDER(2), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)
    ) dut8 (
        .CLK_I(clk), .RST_I(rst), .RX_I(rx8),
        .DATA_O(data8), .VALID_O(valid8), .READY_I(ready8),
        .PARITY_ERR_O(perr8), .FRAME_ERR_O(ferr8),
        .BREAK_O(brk8), .OVERRUN_O(ovr8), .BUSY_O(busy8)
    );

    uart_rx_frame #(
        .OVERSAMPLING(4), .BDDIVIDER(2), .DATA_BITS(7), .PARITY(2), .STOP_BITS(2)
    ) dut7 (
        .CLK_I(clk), .RST_I(rst), .RX_I(rx7),
        .DATA_O(data7), .VALID_O(valid7), .READY_I(ready7),
        .PARITY_ERR_O(perr7), .FRAME_ERR_O(ferr7),
        .BREAK_O(brk7), .OVERRUN_O(ovr7), .BUSY_O(busy7)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    // Consume side: pop and compare whenever a word is handed over.
    always @(negedge clk) begin
        if (!rst) begin
            if (valid8) valid_cycles8++;
            if (valid8 && lat_armed) begin
                check("latency8", cyc - lat_start, 2 + CPB/2 + 9*CPB + 1);
                lat_armed = 1'b0;
            end
            if (valid8 && ready8) begin
                if (q8.size() == 0) begin
                    check("unexpected8", {24'h0, data8}, 32'hFFFF_FFFF);
                end else begin
                    exp_t e;
                    e = q8.pop_front();
                    check("data8", {24'h0, data8}, {23'h0, e.data});
                    check("perr8", {31'h0, perr8}, {31'h0, e.perr});
                    check("ferr8", {31'h0, ferr8}, {31'h0, e.ferr});
                end
            end
            if (valid7 && ready7) begin
                if (q7.size() == 0) begin
                    check("unexpected7", {25'h0, data7}, 32'hFFFF_FFFF);
                end else begin
                    exp_t e;
                    e = q7.pop_front();
                    check("data7", {25'h0, data7}, {23'h0, e.data});
                    check("perr7", {31'h0, perr7}, {31'h0, e.perr});
                    check("ferr7", {31'h0, ferr7}, {31'h0, e.ferr});
                end
            end
            if (brk8) brk_cnt8++;
            if (ovr8) ovr_cnt8++;
            if (brk7) brk_cnt7++;
            if (ovr7) ovr_cnt7++;
        end
    end

    // Drive nbits serial bits (bit 0 first), each CPB clocks, then idle high.
    task automatic send(input bit sel7, input logic [15:0] bits, input int nbits);
        for (int i = 0; i < nbits; i++) begin
            if (sel7) rx7 = bits[i];
            else      rx8 = bits[i];
            repeat (CPB) @(posedge clk);
            #1;
        end
        if (sel7) rx7 = 1'b1;
        else      rx8 = 1'b1;
    endtask

    task automatic frame8(input logic [7:0] d, input logic stop);
        send(1'b0, {5'h0, stop, d, 1'b0}, 10);
    endtask

    task automatic frame7(input logic [6:0] d, input logic p);
        send(1'b1, {4'h0, 2'b11, p, d, 1'b0}, 11);
    endtask

    function automatic exp_t mk(input logic [8:0] d, input logic pe, input logic fe);
        exp_t e;
        e.data = d;
        e.perr = pe;
        e.ferr = fe;
        return e;
    endfunction

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [6:0] d7;
        rst = 1'b1;
        idle(3);
        check("rst_out8", {data8, valid8, perr8, ferr8, brk8, ovr8, busy8}, '0);
        check("rst_out7", {data7, valid7, perr7, ferr7, brk7, ovr7, busy7}, '0);
        rst = 1'b0;
        idle(4);

        // 8N1 basic frame with latency measurement
        q8.push_back(mk(9'h0A5, 1'b0, 1'b0));
        lat_start = cyc;
        lat_armed = 1'b1;
        frame8(8'hA5, 1'b1);
        idle(4);
        check("valid_width8", valid_cycles8, 1);
        check("lat_seen8", {31'h0, lat_armed}, 0);

        // 7E2: good parity then bad parity
        d7 = 7'h55;
        q7.push_back(mk({2'b0, d7}, (^d7) ^ 1'b0, 1'b0));
        q7.push_back(mk({2'b0, d7}, (^d7) ^ 1'b1, 1'b0));
        frame7(d7, 1'b0);
        frame7(d7, 1'b1);
        idle(8);

        // Framing error without break
        q8.push_back(mk(9'h03C, 1'b0, 1'b1));
        frame8(8'h3C, 1'b0);
        idle(8);
        check("no_brk_on_ferr", brk_cnt8, 0);

        // Break: line low for 20 bit times
        begin
            int vc;
            vc = valid_cycles8;
            rx8 = 1'b0;
            idle(20 * CPB);
            check("brk_busy", {31'h0, busy8}, 1);
            check("brk_pulses", brk_cnt8, 1);
            check("brk_novalid", valid_cycles8, vc);
            rx8 = 1'b1;
            idle(4);
            check("brk_release", {31'h0, busy8}, 0);
        end
        idle(8);
        q8.push_back(mk(9'h081, 1'b0, 1'b0));
        frame8(8'h81, 1'b1);
        idle(8);

        // Glitch of two clocks rejected
        begin
            int vc;
            vc = valid_cycles8;
            rx8 = 1'b0;
            idle(2);
            rx8 = 1'b1;
            idle(3);
            check("glitch_busy", {31'h0, busy8}, 1);
            idle(10);
            check("glitch_idle", {31'h0, busy8}, 0);
            check("glitch_novalid", valid_cycles8, vc);
            check("glitch_nobrk", brk_cnt8, 1);
        end

        // Overrun: second back-to-back frame dropped while held
        ready8 = 1'b0;
        q8.push_back(mk(9'h011, 1'b0, 1'b0));
        frame8(8'h11, 1'b1);
        frame8(8'h22, 1'b1);
        idle(6);
        check("ovr_pulses", ovr_cnt8, 1);
        check("ovr_valid", {31'h0, valid8}, 1);
        check("ovr_held", {24'h0, data8}, 32'h11);
        ready8 = 1'b1;
        idle(2);
        check("ovr_drain", {31'h0, valid8}, 0);
        idle(8);

        // Reset during DATA aborts the frame, then a clean frame follows
        send(1'b0, 16'h000E, 4);
        check("mid_busy", {31'h0, busy8}, 1);
        rst = 1'b1;
        idle(1);
        check("mid_rst_out8", {data8, valid8, perr8, ferr8, brk8, ovr8, busy8}, '0);
        rst = 1'b0;
        idle(4);
        q8.push_back(mk(9'h05A, 1'b0, 1'b0));
        frame8(8'h5A, 1'b1);
        idle(10);

        check("q8_drained", q8.size(), 0);
        check("q7_drained", q7.size(), 0);
        check("ovr_total8", ovr_cnt8, 1);
        check("brk_total7", brk_cnt7 + ovr_cnt7, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
